// File: rtl/cpu_defs.sv
// Shared definitions for the CPU instruction sequencer: word layout, opcodes
// and sequencer state encoding.
package cpu_defs;

    localparam int WORD_W = 9;
    localparam int OP_W   = 3;
    localparam int REG_W  = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_MV  = 3'b000;
    localparam opcode_t OP_MVI = 3'b001;
    localparam opcode_t OP_ADD = 3'b010;
    localparam opcode_t OP_SUB = 3'b011;
    localparam opcode_t OP_SRL = 3'b110;
    localparam opcode_t OP_SLL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_t;

    function automatic opcode_t word_opcode(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write port for the loader, two combinational
// read ports so the instruction and its mvi immediate are visible together.
module prog_ram
    import cpu_defs::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [WORD_W-1:0] rdata_a,
    output logic [WORD_W-1:0] rdata_b
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Loader write port; contents deliberately survive reset.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-stream sequencer: issues stored program words to the multicycle
// CPU with Run, supplies mvi immediates during EXEC and advances on Done.
module cpu_sequencer
    import cpu_defs::*;
#(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              busy,
    output logic              prog_done,
    output logic              err,
    output logic [AW-1:0]     pc,
    output logic [AW:0]       retired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t        state_r, state_n;
    logic [AW-1:0]     pc_r, pc_n;
    logic [AW:0]       len_q_r, len_q_n;
    logic [AW:0]       retired_r, retired_n;
    logic [TW-1:0]     tmo_r, tmo_n;
    logic              err_r, err_n;
    logic              busy_r;
    logic              prog_done_r;
    logic              done_pulse_s;
    logic              ram_we_s;
    logic              is_mvi_s;
    logic              mvi_short_s;
    logic              run_s;
    logic [WORD_W-1:0] word_a_s, word_b_s, din_s;
    logic [AW-1:0]     pc_rd_b_s;
    logic [AW:0]       pc_plus1_s, pc_adv_s;

    assign ram_we_s  = load_en && (state_r != ST_ISSUE) && (state_r != ST_EXEC);
    assign pc_rd_b_s = pc_r + AW'(1);

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .Clock   (Clock),
        .we      (ram_we_s),
        .waddr   (load_addr),
        .wdata   (load_data),
        .raddr_a (pc_r),
        .raddr_b (pc_rd_b_s),
        .rdata_a (word_a_s),
        .rdata_b (word_b_s)
    );

    // End-of-program tests use an unwrapped sum so pc reaching DEPTH still finishes.
    assign is_mvi_s    = (word_opcode(word_a_s) == OP_MVI);
    assign pc_plus1_s  = {1'b0, pc_r} + (AW+1)'(1);
    assign pc_adv_s    = {1'b0, pc_r} + (is_mvi_s ? (AW+1)'(2) : (AW+1)'(1));
    assign mvi_short_s = is_mvi_s && (pc_plus1_s >= len_q_r);

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_n      = state_r;
        pc_n         = pc_r;
        len_q_n      = len_q_r;
        retired_n    = retired_r;
        tmo_n        = tmo_r;
        err_n        = err_r;
        done_pulse_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FINISH, ST_ERROR: begin
                if (start) begin
                    len_q_n   = prog_len;
                    pc_n      = '0;
                    retired_n = '0;
                    err_n     = 1'b0;
                    tmo_n     = '0;
                    if (prog_len == '0) begin
                        state_n      = ST_FINISH;
                        done_pulse_s = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            ST_ISSUE: begin
                if (mvi_short_s) begin
                    err_n   = 1'b1;
                    state_n = ST_ERROR;
                end else begin
                    tmo_n   = '0;
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (Done) begin
                    pc_n      = pc_adv_s[AW-1:0];
                    retired_n = retired_r + (AW+1)'(1);
                    if (pc_adv_s >= len_q_r) begin
                        state_n      = ST_FINISH;
                        done_pulse_s = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end else if (tmo_r == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ST_ERROR;
                end else begin
                    tmo_n = tmo_r + TW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r     <= ST_IDLE;
            pc_r        <= '0;
            len_q_r     <= '0;
            retired_r   <= '0;
            tmo_r       <= '0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            prog_done_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            pc_r        <= pc_n;
            len_q_r     <= len_q_n;
            retired_r   <= retired_n;
            tmo_r       <= tmo_n;
            err_r       <= err_n;
            busy_r      <= (state_n == ST_ISSUE) || (state_n == ST_EXEC);
            prog_done_r <= done_pulse_s;
        end
    end

    // DIN/Run decode straight from registered state and RAM: the next word
    // may sit at pc+2, which the dual read port cannot fetch a cycle early.
    always_comb begin
        din_s = '0;
        run_s = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                din_s = word_a_s;
                run_s = !mvi_short_s;
            end
            ST_EXEC: begin
                if (is_mvi_s) begin
                    din_s = word_b_s;
                end else begin
                    din_s = '0;
                end
            end
            default: begin
                din_s = '0;
                run_s = 1'b0;
            end
        endcase
    end

    assign DIN       = din_s;
    assign Run       = run_s;
    assign busy      = busy_r;
    assign prog_done = prog_done_r;
    assign err       = err_r;
    assign pc        = pc_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small behavioural multicycle CPU
// and a queue of expected issued words checked whenever Run is seen.
module tb_cpu_sequencer;
    import cpu_defs::*;

    localparam int AW = 5;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [8:0]    load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic          busy;
    logic          prog_done;
    logic          err;
    logic [AW-1:0] pc;
    logic [AW:0]   retired;

    int n_cmp = 0;
    int n_err = 0;
    int run_cnt = 0;
    int ncyc = 0;
    logic [8:0] exp_q[$];

    cpu_sequencer #(.DEPTH(32), .AW(AW), .TIMEOUT(15)) dut (
        .Clock(Clock), .Resetn(Resetn), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .Done(Done),
        .DIN(DIN), .Run(Run), .busy(busy), .prog_done(prog_done), .err(err),
        .pc(pc), .retired(retired)
    );

    always #5 Clock = ~Clock;

    // Behavioural CPU: T0 takes IR on Run; mv/mvi finish in T1, add/sub in T3.
    logic       cpu_stub = 1'b0;
    logic [1:0] t_r;
    logic [8:0] ir_r = '0;
    logic [8:0] a_r = '0;
    logic [8:0] g_r = '0;
    logic [8:0] rf [8];
    logic [2:0] op_s, rx_s, ry_s;
    assign op_s = ir_r[8:6];
    assign rx_s = ir_r[5:3];
    assign ry_s = ir_r[2:0];
    assign Done = !cpu_stub && (((t_r == 2'd1) && ((op_s == OP_MV) || (op_s == OP_MVI))) || (t_r == 2'd3));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) t_r <= 2'd0;
        else if (!cpu_stub) begin
            case (t_r)
                2'd0: t_r <= Run ? 2'd1 : 2'd0;
                2'd1: t_r <= ((op_s == OP_MV) || (op_s == OP_MVI)) ? 2'd0 : 2'd2;
                2'd2: t_r <= 2'd3;
                default: t_r <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Resetn && !cpu_stub) begin
            case (t_r)
                2'd0: if (Run) ir_r <= DIN;
                2'd1: begin
                    if (op_s == OP_MV) rf[rx_s] <= rf[ry_s];
                    else if (op_s == OP_MVI) rf[rx_s] <= DIN;
                    else a_r <= rf[rx_s];
                end
                2'd2: g_r <= (op_s == OP_SUB) ? (a_r - rf[ry_s]) : (a_r + rf[ry_s]);
                default: rf[rx_s] <= g_r;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        assert (obs === expv) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle, sample at the falling edge, and score any issued word.
    task automatic cyc();
        @(negedge Clock);
        if (Run === 1'b1) begin
            run_cnt = run_cnt + 1;
            if (exp_q.size() == 0) chk("run_unexpected", 32'(Run), 32'd0);
            else chk("issue_din", 32'(DIN), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [8:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic run_prog(input int budget, output int cycles);
        cycles = 0;
        while ((cycles < budget) && (prog_done !== 1'b1)) begin
            cyc();
            start = 1'b0;
            cycles = cycles + 1;
        end
    endtask

    initial begin
        repeat (2) @(negedge Clock);
        chk("rst_din", 32'(DIN), 32'd0);
        chk("rst_run", 32'(Run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_prog_done", 32'(prog_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        Resetn = 1'b1;

        // mvi R0,5 ; mv R1,R0
        load(5'd0, 9'h040); load(5'd1, 9'h005); load(5'd2, 9'h008);
        prog_len = 6'd3; start = 1'b1;
        exp_q.push_back(9'h040); exp_q.push_back(9'h008);
        cyc(); start = 1'b0;
        chk("t1_run_first", 32'(Run), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        cyc();
        chk("t1_imm", 32'(DIN), 32'h005);
        chk("t1_exec_run", 32'(Run), 32'd0);
        cyc();
        chk("t1_run_second", 32'(Run), 32'd1);
        cyc();
        chk("t1_mv_exec_din", 32'(DIN), 32'd0);
        cyc();
        chk("t1_prog_done", 32'(prog_done), 32'd1);
        chk("t1_retired", 32'(retired), 32'd2);
        chk("t1_pc", 32'(pc), 32'd3);
        chk("t1_busy_end", 32'(busy), 32'd0);
        cyc();
        chk("t1_pulse_once", 32'(prog_done), 32'd0);
        chk("t1_r0", 32'(rf[0]), 32'd5);
        chk("t1_r1", 32'(rf[1]), 32'd5);

        // mvi R0,3 ; mvi R1,4 ; add R0,R1
        load(5'd0, 9'h040); load(5'd1, 9'h003); load(5'd2, 9'h048);
        load(5'd3, 9'h004); load(5'd4, 9'h081);
        prog_len = 6'd5; start = 1'b1; run_cnt = 0;
        exp_q.push_back(9'h040); exp_q.push_back(9'h048); exp_q.push_back(9'h081);
        run_prog(40, ncyc);
        chk("t2_cycles", 32'(ncyc), 32'd9);
        chk("t2_retired", 32'(retired), 32'd3);
        chk("t2_runs", 32'(run_cnt), 32'd3);
        chk("t2_r0", 32'(rf[0]), 32'd7);
        cyc();
        chk("t2_pulse_once", 32'(prog_done), 32'd0);

        // Empty program
        prog_len = 6'd0; start = 1'b1; run_cnt = 0;
        cyc(); start = 1'b0;
        chk("t3_prog_done", 32'(prog_done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        cyc();
        chk("t3_pulse_once", 32'(prog_done), 32'd0);
        chk("t3_err", 32'(err), 32'd0);
        chk("t3_retired", 32'(retired), 32'd0);
        chk("t3_runs", 32'(run_cnt), 32'd0);

        // Truncated mvi
        prog_len = 6'd1; start = 1'b1; run_cnt = 0;
        cyc(); start = 1'b0;
        chk("t4_issue_busy", 32'(busy), 32'd1);
        cyc();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        cyc();
        chk("t4_err_sticky", 32'(err), 32'd1);
        chk("t4_no_done", 32'(prog_done), 32'd0);
        chk("t4_runs", 32'(run_cnt), 32'd0);
        prog_len = 6'd5; start = 1'b1;
        exp_q.push_back(9'h040); exp_q.push_back(9'h048); exp_q.push_back(9'h081);
        cyc(); start = 1'b0;
        chk("t4_err_cleared", 32'(err), 32'd0);
        run_prog(40, ncyc);
        chk("t4_rerun_cycles", 32'(ncyc), 32'd8);
        chk("t4_rerun_r0", 32'(rf[0]), 32'd7);

        // Stubbed CPU: timeout, and loads ignored while busy
        cpu_stub = 1'b1; prog_len = 6'd5; start = 1'b1;
        exp_q.push_back(9'h040);
        cyc(); start = 1'b0;
        cyc();
        load_en = 1'b1; load_addr = 5'd0; load_data = 9'h1FF;
        cyc();
        load_en = 1'b0;
        repeat (13) cyc();
        chk("t5_still_exec", 32'(busy), 32'd1);
        chk("t5_no_err_yet", 32'(err), 32'd0);
        cyc();
        chk("t5_timeout_err", 32'(err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_retired", 32'(retired), 32'd0);
        Resetn = 1'b0; cpu_stub = 1'b0;
        cyc();
        Resetn = 1'b1;

        // Asynchronous reset in EXEC, then a clean rerun
        prog_len = 6'd5; start = 1'b1;
        exp_q.push_back(9'h040); exp_q.push_back(9'h048); exp_q.push_back(9'h081);
        cyc(); start = 1'b0;
        cyc();
        chk("t6_exec_imm", 32'(DIN), 32'h003);
        #2 Resetn = 1'b0;
        #1;
        chk("t6_async_din", 32'(DIN), 32'd0);
        chk("t6_async_run", 32'(Run), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_pc", 32'(pc), 32'd0);
        exp_q.delete();
        @(negedge Clock);
        Resetn = 1'b1;
        prog_len = 6'd5; start = 1'b1;
        exp_q.push_back(9'h040); exp_q.push_back(9'h048); exp_q.push_back(9'h081);
        run_prog(40, ncyc);
        chk("t6_rerun_cycles", 32'(ncyc), 32'd9);
        chk("t6_rerun_retired", 32'(retired), 32'd3);
        chk("t6_rerun_r0", 32'(rf[0]), 32'd7);
        chk("t6_rerun_err", 32'(err), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
